// File: rtl/pulse_width_capture.sv
// ============================================================================
// Module   : pulse_width_capture
// Brief    : Measures the length of the upstream counting phase and presents
//            each result on a one-entry valid/ready output register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_width_capture #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 waiting,
    input  logic                 counting,
    input  logic                 data_ready,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_saturated,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_MEAS     = 2'd2,
        ST_CAPTURED = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
    logic                   out_saturated_q, out_saturated_d;
    logic                   overrun_q, overrun_d;
    logic                   w_capture;
    logic                   w_accept;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sat_d           = sat_q;
        w_capture       = 1'b0;

        if (waiting) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (counting) begin
                        state_d = ST_MEAS;
                        cnt_d   = C_CNT_ONE;
                        sat_d   = (C_CNT_ONE == C_CNT_MAX);
                    end
                end
                ST_MEAS: begin
                    if (counting) begin
                        // Saturating increment: never wraps past all-ones.
                        cnt_d = (cnt_q == C_CNT_MAX) ? C_CNT_MAX : cnt_q + C_CNT_ONE;
                        sat_d = (cnt_d == C_CNT_MAX);
                    end else if (data_ready) begin
                        w_capture = 1'b1;
                        state_d   = ST_CAPTURED;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // A capture may land in the same cycle the consumer pops the old result.
    assign w_accept = w_capture && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d     = out_valid_q;
        out_count_d     = out_count_q;
        out_saturated_d = out_saturated_q;
        overrun_d       = overrun_q && !clr_err;

        if (w_accept) begin
            out_valid_d     = 1'b1;
            out_count_d     = cnt_q;
            out_saturated_d = sat_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_capture && !w_accept) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            sat_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            out_count_q     <= '0;
            out_saturated_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sat_q           <= sat_d;
            out_valid_q     <= out_valid_d;
            out_count_q     <= out_count_d;
            out_saturated_q <= out_saturated_d;
            overrun_q       <= overrun_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_count     = out_count_q;
    assign out_saturated = out_saturated_q;
    assign overrun_err   = overrun_q;
    assign busy          = (state_q == ST_ARMED) || (state_q == ST_MEAS);

endmodule

`default_nettype wire
